aes_inv_round: RTL
==================

AES_INV_ROUND -- requirements
Module: aes_inv_round

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 128 bits and the byte rate at one byte per cycle.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to run one decryption round on state_in/round_key; sampled only in IDLE.
REQ-005 last_round  input  1  1 = omit InvMixColumns (final decryption round); sampled with start.
REQ-006 state_in  input  128  round input state; byte k = state_in[127-8k -: 8]; column-major per FIPS-197 (byte k = row k%4, column k/4).
REQ-007 round_key  input  128  round key, same byte order; sampled with start.
REQ-008 busy  output  1  high while a round is in progress.
REQ-009 done  output  1  one-cycle pulse; state_out is valid from this cycle on.
REQ-010 state_out  output  128  round result; holds its value until the next completion or reset.

Function
REQ-011 The block SHALL compute state_out = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_in)), round_key)); when last_round=1, the InvMixColumns step is omitted.
REQ-012 The FSM SHALL have the states IDLE, SUB and MIX, and SHALL reset into IDLE.
REQ-013 In IDLE with start=1, the block SHALL register InvShiftRows(state_in) into the working state, latch round_key and last_round, clear the byte counter to 0, and go to SUB.
REQ-014 In SUB, on each edge the block SHALL replace working byte[cnt] with InvSbox(byte[cnt]) and increment the 4-bit cnt; after cnt=15 it SHALL go to MIX. SUB lasts exactly 16 cycles.
REQ-015 InvSbox SHALL be the exact FIPS-197 inverse S-box (inverse affine transform followed by GF(2^8) inversion modulo x^8+x^4+x^3+x+1, with 0 mapping to 0), implemented combinationally for a single byte.
REQ-016 In MIX, the block SHALL XOR the working state with the latched key, apply InvMixColumns per column if last_round=0, register the result into state_out, set done=1 for the next cycle, and return to IDLE.
REQ-017 InvMixColumns SHALL use the coefficients {0e,0b,0d,09} in GF(2^8); xtime SHALL reduce by 0x1B.
REQ-018 Latency: done SHALL be high in the cycle following the 18th rising edge counted from, and including, the edge that accepted start.
REQ-019 busy SHALL be 1 in the cycles following the accept edge through MIX, and SHALL be 0 in IDLE, including the done cycle.
REQ-020 start SHALL be ignored while busy=1; state_in, round_key and last_round need not be held after the accept edge.
REQ-021 A start in the done cycle SHALL be accepted (back-to-back), and state_out SHALL keep the previous result until the new MIX edge.
REQ-022 done SHALL never be high for more than one consecutive cycle unless rounds are issued back to back.

Reset
REQ-023 While reset=1, the block SHALL force IDLE, with busy=0, done=0, state_out=0, cnt=0 and the working state cleared; reset takes priority over start.
REQ-024 A reset during SUB or MIX SHALL abort the round with no done pulse; the first start after reset is deasserted SHALL behave as in REQ-013.

Verification
REQ-025 Inner round: state_in=7ad5fda789ef4e272bca100b3d9ff59f, round_key=549932d1f08557681093ed9cbe2c974e, last_round=0 -> state_out=54d990a16ba09ab596bbf40ea111702f, done at the REQ-018 cycle.
REQ-026 Same inputs with last_round=1 -> state_out=e9f74eec023020f61bf2ccf2353c21c7.
REQ-027 Final round: state_in=6353e08c0960e104cd70b751bacad0e7, round_key=000102030405060708090a0b0c0d0e0f, last_round=1 -> state_out=00112233445566778899aabbccddeeff.
REQ-028 InvSbox spot checks: an all-0x63 state_in with a zero key and last_round=1 -> all-0x00; an all-0x00 state_in under the same conditions -> all-0x52.
REQ-029 Pulse start again at cycle 5 of a round -> it is ignored, exactly one done occurs, and the result is unchanged; start in the done cycle -> a second done 18 edges later with the second result.
REQ-030 Assert reset at SUB cycle 8 -> busy=0, done=0 and state_out=0 on the next edge with no done pulse; a subsequent REQ-025 run completes correctly.

Source files
------------

// File: rtl/aes_inv_round.sv
// One AES decryption round, processed one S-box byte per cycle.
// Sequence: InvShiftRows on accept, 16 single-byte InvSubBytes steps,
// then AddRoundKey and (unless last_round) InvMixColumns in a final cycle.
module aes_inv_round (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         last_round,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

    state_t       state_reg, state_next;
    logic [127:0] work_reg, work_next;
    logic [127:0] key_reg, key_next;
    logic [127:0] out_reg, out_next;
    logic         last_reg, last_next;
    logic         done_reg, done_next;
    logic [3:0]   cnt_reg, cnt_next;

    logic [127:0] shifted;
    logic [127:0] sub_state;
    logic [127:0] keyed;
    logic [127:0] mixed;
    logic [7:0]   work_byte [16];
    logic [7:0]   sbox_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 = a^-1 for a != 0; 0 stays 0 because the product collapses.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign shifted[127-8*gi -: 8]   = state_in[127-8*SRC -: 8];
            assign work_byte[gi]            = work_reg[127-8*gi -: 8];
            assign sub_state[127-8*gi -: 8] = (cnt_reg == 4'(gi)) ? sbox_out : work_byte[gi];
        end
    endgenerate

    // A single S-box is shared across the 16 SUB cycles.
    assign sbox_out = inv_sbox(work_byte[cnt_reg]);
    assign keyed    = work_reg ^ key_reg;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_cols
            assign mixed[127-32*gi -: 32] = inv_mix_col(keyed[127-32*gi -: 32]);
        end
    endgenerate

    // Next-state and datapath control.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        key_next   = key_reg;
        out_next   = out_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    work_next  = shifted;
                    key_next   = round_key;
                    last_next  = last_round;
                    cnt_next   = 4'd0;
                    state_next = SUB;
                end
            end
            SUB: begin
                work_next = sub_state;
                cnt_next  = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) state_next = MIX;
            end
            MIX: begin
                out_next   = last_reg ? keyed : mixed;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            key_reg   <= '0;
            out_reg   <= '0;
            last_reg  <= 1'b0;
            cnt_reg   <= 4'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            key_reg   <= key_next;
            out_reg   <= out_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign state_out = out_reg;

endmodule
